// File: rtl/ep_protocol_ctrl.sv
// USB bulk endpoint protocol controller: DATA0/DATA1 toggle tracking, payload
// commit/flush decisions, handshake/data scheduling and bus-direction ownership.
module ep_protocol_ctrl #(
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rx_packet_valid,
  input  logic [3:0] rx_pid,
  input  logic       rx_error,
  input  logic       rx_overflow,
  input  logic       tx_data_ready,
  input  logic       tx_done,
  input  logic       clear_toggle,
  output logic       tx_start,
  output logic [3:0] tx_pid,
  output logic       rx_commit,
  output logic       rx_flush,
  output logic       tx_commit,
  output logic       d_mode,
  output logic       rx_toggle,
  output logic       tx_toggle,
  output logic [7:0] err_count
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] PID_OUT = 4'b0001;
  localparam logic [3:0] PID_IN  = 4'b1001;
  localparam logic [3:0] PID_ACK = 4'b0010;
  localparam logic [3:0] PID_NAK = 4'b1010;

  typedef enum logic [2:0] {
    IDLE, WAIT_DATA, SEND_HS, SEND_DATA, WAIT_TX, WAIT_ACK
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [3:0]    pid_nxt;
  logic          start_nxt, rcommit_nxt, flush_nxt, tcommit_nxt, dmode_nxt;
  logic          rtog_nxt, ttog_nxt, timeout;

  // An errored packet is never acted on, whatever state we are in.
  wire pkt      = rx_packet_valid & ~rx_error;
  wire pid_data = (rx_pid[2:0] == 3'b011);
  wire at_limit = (timer == TLAST);

  always_comb begin
    state_nxt   = state;
    timer_nxt   = '0;
    pid_nxt     = tx_pid;
    start_nxt   = 1'b0;
    rcommit_nxt = 1'b0;
    flush_nxt   = 1'b0;
    tcommit_nxt = 1'b0;
    rtog_nxt    = rx_toggle;
    ttog_nxt    = tx_toggle;
    timeout     = 1'b0;
    case (state)
      IDLE: begin
        if (pkt && rx_pid == PID_OUT) begin
          state_nxt = WAIT_DATA;
        end else if (pkt && rx_pid == PID_IN) begin
          start_nxt = 1'b1;
          if (tx_data_ready) begin
            state_nxt = SEND_DATA;
            pid_nxt   = {tx_toggle, 3'b011};
          end else begin
            state_nxt = SEND_HS;
            pid_nxt   = PID_NAK;
          end
        end
      end
      WAIT_DATA: begin
        timer_nxt = timer + TW'(1);
        if (rx_error) begin
          flush_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (pkt && pid_data) begin
          state_nxt = SEND_HS;
          start_nxt = 1'b1;
          if (rx_overflow) begin
            flush_nxt = 1'b1;
            pid_nxt   = PID_NAK;
          end else if (rx_pid[3] == rx_toggle) begin
            rcommit_nxt = 1'b1;
            rtog_nxt    = ~rx_toggle;
            pid_nxt     = PID_ACK;
          end else begin
            // Host missed our last ACK: ack again but drop the duplicate.
            flush_nxt = 1'b1;
            pid_nxt   = PID_ACK;
          end
        end else if (pkt) begin
          flush_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (at_limit) begin
          timeout   = 1'b1;
          flush_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      SEND_HS, SEND_DATA: state_nxt = WAIT_TX;
      WAIT_TX: begin
        if (tx_done) state_nxt = (tx_pid[1:0] == 2'b11) ? WAIT_ACK : IDLE;
      end
      WAIT_ACK: begin
        timer_nxt = timer + TW'(1);
        if (rx_error) begin
          state_nxt = IDLE;
        end else if (pkt) begin
          state_nxt = IDLE;
          if (rx_pid == PID_ACK) begin
            tcommit_nxt = 1'b1;
            ttog_nxt    = ~tx_toggle;
          end
        end else if (at_limit) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (clear_toggle) begin
      rtog_nxt = 1'b0;
      ttog_nxt = 1'b0;
    end
    dmode_nxt = (state_nxt == SEND_HS) || (state_nxt == SEND_DATA) || (state_nxt == WAIT_TX);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      timer     <= '0;
      tx_start  <= 1'b0;
      tx_pid    <= 4'b0000;
      rx_commit <= 1'b0;
      rx_flush  <= 1'b0;
      tx_commit <= 1'b0;
      d_mode    <= 1'b0;
      rx_toggle <= 1'b0;
      tx_toggle <= 1'b0;
      err_count <= 8'd0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      tx_start  <= start_nxt;
      tx_pid    <= pid_nxt;
      rx_commit <= rcommit_nxt;
      rx_flush  <= flush_nxt;
      tx_commit <= tcommit_nxt;
      d_mode    <= dmode_nxt;
      rx_toggle <= rtog_nxt;
      tx_toggle <= ttog_nxt;
      if ((rx_error || timeout) && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_ep_protocol_ctrl.sv
// Randomized transaction-level bench for ep_protocol_ctrl against a small
// model of the endpoint's toggles and error counter.
module tb_ep_protocol_ctrl;
  localparam int T = 128;
  localparam logic [3:0] OUT = 4'b0001, IN = 4'b1001, D0 = 4'b0011, D1 = 4'b1011,
                         ACK = 4'b0010, NAK = 4'b1010;

  logic clk = 1'b0, n_rst = 1'b0;
  logic rx_packet_valid = 0, rx_error = 0, rx_overflow = 0, tx_data_ready = 0;
  logic tx_done = 0, clear_toggle = 0;
  logic [3:0] rx_pid = 4'd0;
  logic tx_start, rx_commit, rx_flush, tx_commit, d_mode, rx_toggle, tx_toggle;
  logic [3:0] tx_pid;
  logic [7:0] err_count;

  ep_protocol_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .n_rst(n_rst), .rx_packet_valid(rx_packet_valid), .rx_pid(rx_pid),
    .rx_error(rx_error), .rx_overflow(rx_overflow), .tx_data_ready(tx_data_ready),
    .tx_done(tx_done), .clear_toggle(clear_toggle), .tx_start(tx_start), .tx_pid(tx_pid),
    .rx_commit(rx_commit), .rx_flush(rx_flush), .tx_commit(tx_commit), .d_mode(d_mode),
    .rx_toggle(rx_toggle), .tx_toggle(tx_toggle), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit m_rx = 0, m_tx = 0;
  int m_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pkt(input logic [3:0] p, input bit err, input bit clr);
    rx_packet_valid = 1; rx_pid = p; rx_error = err; clear_toggle = clr;
    step();
    rx_packet_valid = 0; rx_error = 0; clear_toggle = 0;
  endtask

  function automatic void err_inc();
    if (m_err < 255) m_err++;
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, "_rxtog"}, rx_toggle, m_rx);
    chk({tag, "_txtog"}, tx_toggle, m_tx);
    chk({tag, "_err"}, err_count, m_err);
  endtask

  // Called in the tx_start cycle; runs the transmit through tx_done.
  task automatic finish_tx();
    step();
    chk("wtx_start", tx_start, 0);
    repeat ($urandom_range(0, 3)) step();
    chk("wtx_dmode", d_mode, 1);
    tx_done = 1; step(); tx_done = 0;
    chk("post_dmode", d_mode, 0);
  endtask

  task automatic out_txn();
    bit ov, d, clr;
    logic [3:0] epid;
    pkt(OUT, 0, 0);
    chk("out_nostart", tx_start, 0);
    repeat ($urandom_range(0, 5)) step();
    ov = ($urandom % 4) == 0; d = $urandom % 2; clr = ($urandom % 8) == 0;
    rx_overflow = ov;
    pkt(d ? D1 : D0, 0, clr);
    rx_overflow = 0;
    if (ov) begin
      epid = NAK; chk("ov_flush", rx_flush, 1); chk("ov_commit", rx_commit, 0);
    end else if (d == m_rx) begin
      epid = ACK; chk("new_commit", rx_commit, 1); chk("new_flush", rx_flush, 0);
      m_rx = ~m_rx;
    end else begin
      epid = ACK; chk("dup_flush", rx_flush, 1); chk("dup_commit", rx_commit, 0);
    end
    if (clr) begin m_rx = 0; m_tx = 0; end
    chk("hs_start", tx_start, 1);
    chk("hs_pid", tx_pid, epid);
    chk("hs_dmode", d_mode, 1);
    chk_model("out");
    finish_tx();
  endtask

  task automatic in_txn();
    bit rdy, clr;
    int resp, k;
    logic [7:0] prev;
    rdy = ($urandom % 4) != 0;
    tx_data_ready = rdy;
    pkt(IN, 0, 0);
    tx_data_ready = 0;
    chk("in_start", tx_start, 1);
    chk("in_dmode", d_mode, 1);
    chk("in_pid", tx_pid, rdy ? {m_tx, 3'b011} : NAK);
    finish_tx();
    if (rdy) begin
      resp = $urandom % 5;
      case (resp)
        0: begin
          repeat ($urandom_range(0, 5)) step();
          clr = ($urandom % 4) == 0;
          pkt(ACK, 0, clr);
          chk("ack_commit", tx_commit, 1);
          m_tx = ~m_tx;
          if (clr) begin m_rx = 0; m_tx = 0; end
        end
        1: begin
          pkt(NAK, 0, 0);
          chk("nak_commit", tx_commit, 0);
        end
        2: begin
          pkt(ACK, 1, 0);
          chk("err_commit", tx_commit, 0);
          err_inc();
        end
        3: begin
          prev = err_count;
          k = 0;
          for (int i = 1; i <= T + 20; i++) begin
            step();
            if (tx_commit) k = -1000;
            if (err_count != prev) begin k += i; break; end
          end
          chk("ack_timeout_cycles", k, T);
          err_inc();
        end
        default: begin
          repeat (T - 1) step();
          pkt(ACK, 0, 0);
          chk("late_ack_commit", tx_commit, 1);
          m_tx = ~m_tx;
        end
      endcase
    end
    chk_model("in");
  endtask

  task automatic abort_txn();
    int sel, k;
    pkt(OUT, 0, 0);
    sel = $urandom % 3;
    if (sel == 0) begin
      pkt(D0, 1, 0);
      err_inc();
      chk("rxerr_flush", rx_flush, 1);
      chk("rxerr_start", tx_start, 0);
    end else if (sel == 1) begin
      pkt(($urandom % 2) ? IN : NAK, 0, 0);
      chk("tok_flush", rx_flush, 1);
      chk("tok_start", tx_start, 0);
    end else begin
      k = 0;
      for (int i = 1; i <= T + 20; i++) begin
        step();
        if (rx_flush) begin k = i; break; end
      end
      chk("data_timeout_cycles", k, T);
      err_inc();
    end
    chk("abort_commit", rx_commit, 0);
    chk_model("abort");
  endtask

  task automatic idle_noise();
    int sel;
    sel = $urandom % 4;
    case (sel)
      0: begin
        pkt(($urandom % 2) ? D1 : ACK, 0, 0);
        chk("ign_start", tx_start, 0);
        chk("ign_flush", rx_flush, 0);
      end
      1: begin pkt(IN, 1, 0); err_inc(); chk("ign_errpkt_start", tx_start, 0); end
      2: begin tx_done = 1; step(); tx_done = 0; chk("stray_done_dmode", d_mode, 0); end
      default: begin clear_toggle = 1; step(); clear_toggle = 0; m_rx = 0; m_tx = 0; end
    endcase
    chk_model("idle");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"}, tx_start, 0);
    chk({tag, "_pid"}, tx_pid, 0);
    chk({tag, "_rcommit"}, rx_commit, 0);
    chk({tag, "_flush"}, rx_flush, 0);
    chk({tag, "_tcommit"}, tx_commit, 0);
    chk({tag, "_dmode"}, d_mode, 0);
    chk({tag, "_rxtog"}, rx_toggle, 0);
    chk({tag, "_txtog"}, tx_toggle, 0);
    chk({tag, "_err"}, err_count, 0);
  endtask

  initial begin
    repeat (3) step();
    chk_reset_outputs("rst");
    n_rst = 1;
    step();

    // Fixed opening sequence from fresh toggles, then random mix.
    rx_overflow = 0;
    pkt(OUT, 0, 0); pkt(D0, 0, 0);
    chk("first_commit", rx_commit, 1);
    chk("first_pid", tx_pid, ACK);
    m_rx = 1;
    chk_model("first");
    finish_tx();

    for (int n = 0; n < 200; n++) begin
      case ($urandom % 4)
        0: out_txn();
        1: in_txn();
        2: abort_txn();
        default: idle_noise();
      endcase
      repeat ($urandom_range(0, 2)) step();
    end

    for (int n = 0; n < 300; n++) begin
      rx_error = 1; step(); rx_error = 0;
      err_inc();
    end
    chk("err_saturate", err_count, 8'hFF);

    tx_data_ready = 1;
    pkt(IN, 0, 0);
    tx_data_ready = 0;
    step();
    #2 n_rst = 0;
    #1 chk_reset_outputs("midrst");
    step();
    n_rst = 1;
    m_rx = 0; m_tx = 0; m_err = 0;
    step();
    chk_model("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
